// File: rtl/card_eval_unit_pkg.sv
// ---------------------------------------------------------------------------
// card_eval_unit_pkg : shared constants and match-result code for the card game
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package card_eval_unit_pkg;

  localparam int NUM_CARDS = 9;
  localparam int CARD_W    = 4;

  typedef logic [1:0] match_t;

  localparam match_t MATCH_DRAW = 2'b00;
  localparam match_t MATCH_P1   = 2'b01;
  localparam match_t MATCH_P2   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/card_eval_unit_color_count.sv
// ---------------------------------------------------------------------------
// card_color_count : counts black (odd) and white (even) cards left in a mask
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module card_color_count
  import card_eval_unit_pkg::*;
#(
  parameter int N = NUM_CARDS
) (
  input  logic [N-1:0]      mask_i,
  output logic [CARD_W-1:0] black_o,
  output logic [CARD_W-1:0] white_o
);

  always_comb begin
    black_o = '0;
    white_o = '0;
    for (int k = 0; k < N; k++) begin
      if ((k % 2) == 1) black_o = black_o + CARD_W'(mask_i[k]);
      else              white_o = white_o + CARD_W'(mask_i[k]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/card_eval_unit.sv
// ---------------------------------------------------------------------------
// card_eval_unit : registered colour counts, hand compare and switch encoder
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module card_eval_unit #(
  parameter int NUM_CARDS = card_eval_unit_pkg::NUM_CARDS,
  parameter int ENC_WIDTH = 16,
  parameter int IDX_WIDTH = 4
) (
  input  logic                          clk_i,
  input  logic                          resetn_i,
  input  logic [NUM_CARDS-1:0]          p1_cards_i,
  input  logic [NUM_CARDS-1:0]          p2_cards_i,
  input  logic [IDX_WIDTH-1:0]          p1_hand_i,
  input  logic [IDX_WIDTH-1:0]          p2_hand_i,
  input  logic [ENC_WIDTH-1:0]          sel_vec_i,
  output logic [3:0]                    p1_black_o,
  output logic [3:0]                    p1_white_o,
  output logic [3:0]                    p2_black_o,
  output logic [3:0]                    p2_white_o,
  output card_eval_unit_pkg::match_t    match_result_o,
  output logic                          p1_hand_black_o,
  output logic                          p2_hand_black_o,
  output logic [IDX_WIDTH-1:0]          sel_index_o,
  output logic                          sel_valid_o
);

  logic [3:0]                 p1_black_d, p1_white_d, p2_black_d, p2_white_d;
  card_eval_unit_pkg::match_t match_d;
  logic [IDX_WIDTH-1:0]       sel_index_d;
  logic                       sel_valid_d;

  card_color_count #(.N(NUM_CARDS)) u_p1_count (
    .mask_i  (p1_cards_i),
    .black_o (p1_black_d),
    .white_o (p1_white_d)
  );

  card_color_count #(.N(NUM_CARDS)) u_p2_count (
    .mask_i  (p2_cards_i),
    .black_o (p2_black_d),
    .white_o (p2_white_d)
  );

  always_comb begin
    if (p1_hand_i > p2_hand_i)      match_d = card_eval_unit_pkg::MATCH_P1;
    else if (p2_hand_i > p1_hand_i) match_d = card_eval_unit_pkg::MATCH_P2;
    else                            match_d = card_eval_unit_pkg::MATCH_DRAW;
  end

  // Ascending scan: a later (higher) set bit overwrites earlier ones.
  always_comb begin
    sel_index_d = '0;
    sel_valid_d = 1'b0;
    for (int i = 0; i < ENC_WIDTH; i++) begin
      if (sel_vec_i[i]) begin
        sel_index_d = IDX_WIDTH'(i);
        sel_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      p1_black_o      <= '0;
      p1_white_o      <= '0;
      p2_black_o      <= '0;
      p2_white_o      <= '0;
      match_result_o  <= card_eval_unit_pkg::MATCH_DRAW;
      p1_hand_black_o <= 1'b0;
      p2_hand_black_o <= 1'b0;
      sel_index_o     <= '0;
      sel_valid_o     <= 1'b0;
    end else begin
      p1_black_o      <= p1_black_d;
      p1_white_o      <= p1_white_d;
      p2_black_o      <= p2_black_d;
      p2_white_o      <= p2_white_d;
      match_result_o  <= match_d;
      p1_hand_black_o <= p1_hand_i[0];
      p2_hand_black_o <= p2_hand_i[0];
      sel_index_o     <= sel_index_d;
      sel_valid_o     <= sel_valid_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_card_eval_unit.sv
// ---------------------------------------------------------------------------
// tb_card_eval_unit : vector table, sweeps and random stimulus vs. a model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_card_eval_unit;

  typedef struct packed {
    logic        rstn;
    logic [8:0]  c1;
    logic [8:0]  c2;
    logic [3:0]  h1;
    logic [3:0]  h2;
    logic [15:0] sel;
  } in_t;

  typedef struct packed {
    logic [3:0] p1b;
    logic [3:0] p1w;
    logic [3:0] p2b;
    logic [3:0] p2w;
    logic [1:0] mr;
    logic       h1b;
    logic       h2b;
    logic [3:0] idx;
    logic       v;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t e;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic [8:0]  p1_cards, p2_cards;
  logic [3:0]  p1_hand, p2_hand;
  logic [15:0] sel_vec;
  logic [3:0]  p1_black, p1_white, p2_black, p2_white;
  logic [1:0]  match_result;
  logic        p1_hand_black, p2_hand_black;
  logic [3:0]  sel_index;
  logic        sel_valid;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  card_eval_unit dut (
    .clk_i           (clk),
    .resetn_i        (resetn),
    .p1_cards_i      (p1_cards),
    .p2_cards_i      (p2_cards),
    .p1_hand_i       (p1_hand),
    .p2_hand_i       (p2_hand),
    .sel_vec_i       (sel_vec),
    .p1_black_o      (p1_black),
    .p1_white_o      (p1_white),
    .p2_black_o      (p2_black),
    .p2_white_o      (p2_white),
    .match_result_o  (match_result),
    .p1_hand_black_o (p1_hand_black),
    .p2_hand_black_o (p2_hand_black),
    .sel_index_o     (sel_index),
    .sel_valid_o     (sel_valid)
  );

  // Reference model written from the game rules: colour counts are popcounts
  // of the odd/even card positions, the encoder searches from the top down.
  function automatic out_t model(input in_t x);
    out_t r;
    bit   found;
    r = '0;
    if (x.rstn) begin
      r.p1b = 4'($countones(x.c1 & 9'h0AA));
      r.p1w = 4'($countones(x.c1 & 9'h155));
      r.p2b = 4'($countones(x.c2 & 9'h0AA));
      r.p2w = 4'($countones(x.c2 & 9'h155));
      r.mr  = (x.h1 > x.h2) ? 2'b01 : ((x.h1 < x.h2) ? 2'b10 : 2'b00);
      r.h1b = (x.h1 % 2) == 1;
      r.h2b = (x.h2 % 2) == 1;
      found = 1'b0;
      for (int k = 15; k >= 0; k--) begin
        if (!found && x.sel[k]) begin
          r.idx = 4'(k);
          r.v   = 1'b1;
          found = 1'b1;
        end
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_and_check(input string tag, input in_t x, input out_t e);
    resetn   = x.rstn;
    p1_cards = x.c1;
    p2_cards = x.c2;
    p1_hand  = x.h1;
    p2_hand  = x.h2;
    sel_vec  = x.sel;
    @(posedge clk);
    #1;
    chk({tag, ".p1_black"},      p1_black,      e.p1b);
    chk({tag, ".p1_white"},      p1_white,      e.p1w);
    chk({tag, ".p2_black"},      p2_black,      e.p2b);
    chk({tag, ".p2_white"},      p2_white,      e.p2w);
    chk({tag, ".match_result"},  match_result,  e.mr);
    chk({tag, ".p1_hand_black"}, p1_hand_black, e.h1b);
    chk({tag, ".p2_hand_black"}, p2_hand_black, e.h2b);
    chk({tag, ".sel_index"},     sel_index,     e.idx);
    chk({tag, ".sel_valid"},     sel_valid,     e.v);
  endtask

  function automatic in_t rand_in(input bit rstn);
    in_t x;
    x.rstn = rstn;
    x.c1   = 9'($urandom);
    x.c2   = 9'($urandom);
    x.h1   = 4'($urandom_range(0, 15));
    x.h2   = 4'($urandom_range(0, 15));
    x.sel  = ($urandom_range(0, 3) == 0) ? 16'h0 : (16'($urandom) & 16'h01FF);
    return x;
  endfunction

  vec_t vecs[9];

  initial begin
    in_t x;

    // Hand-derived expectations; fields: p1b p1w p2b p2w mr h1b h2b idx v
    vecs[0] = '{i: '{1'b0, 9'h1FF, 9'h1FF, 4'd8, 4'd3, 16'h0100},
                e: '{4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0}};
    vecs[1] = '{i: '{1'b1, 9'h1FF, 9'h000, 4'd8, 4'd8, 16'h0100},
                e: '{4'd4, 4'd5, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 4'd8, 1'b1}};
    vecs[2] = '{i: '{1'b1, 9'b000001010, 9'b100010001, 4'd7, 4'd3, 16'h0001},
                e: '{4'd2, 4'd0, 4'd0, 4'd3, 2'b01, 1'b1, 1'b1, 4'd0, 1'b1}};
    vecs[3] = '{i: '{1'b1, 9'h000, 9'h1FF, 4'd2, 4'd6, 16'h0000},
                e: '{4'd0, 4'd0, 4'd4, 4'd5, 2'b10, 1'b0, 1'b0, 4'd0, 1'b0}};
    vecs[4] = '{i: '{1'b1, 9'h0AA, 9'h155, 4'd5, 4'd5, 16'h0012},
                e: '{4'd4, 4'd0, 4'd0, 4'd5, 2'b00, 1'b1, 1'b1, 4'd4, 1'b1}};
    vecs[5] = '{i: '{1'b1, 9'h101, 9'h080, 4'd15, 4'd9, 16'h8001},
                e: '{4'd0, 4'd2, 4'd1, 4'd0, 2'b01, 1'b1, 1'b1, 4'd15, 1'b1}};
    vecs[6] = '{i: '{1'b1, 9'h002, 9'h100, 4'd0, 4'd12, 16'h0180},
                e: '{4'd1, 4'd0, 4'd0, 4'd1, 2'b10, 1'b0, 1'b0, 4'd8, 1'b1}};
    vecs[7] = '{i: '{1'b0, 9'h1FF, 9'h1FF, 4'd9, 4'd1, 16'hFFFF},
                e: '{4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0}};
    vecs[8] = '{i: '{1'b1, 9'h0FF, 9'h1FE, 4'd1, 4'd0, 16'h0040},
                e: '{4'd4, 4'd4, 4'd4, 4'd4, 2'b01, 1'b1, 1'b0, 4'd6, 1'b1}};

    resetn = 1'b0; p1_cards = '0; p2_cards = '0;
    p1_hand = '0; p2_hand = '0; sel_vec = '0;
    @(posedge clk);
    #1;

    for (int n = 0; n < 9; n++)
      apply_and_check($sformatf("vec%0d", n), vecs[n].i, vecs[n].e);

    // Mid-stream single-cycle reset: zeros for exactly that cycle, then tracking.
    for (int n = 0; n < 6; n++) begin
      x = rand_in(n != 3);
      apply_and_check($sformatf("midrst%0d", n), x, model(x));
    end

    for (int m = 0; m < 512; m++) begin
      x = '{1'b1, 9'(m), 9'(~m), 4'(m % 16), 4'(m / 32), 16'(1 << (m % 16))};
      apply_and_check($sformatf("mask%0d", m), x, model(x));
    end

    for (int a = 0; a < 9; a++)
      for (int b = 0; b < 9; b++) begin
        x = '{1'b1, 9'h1FF, 9'h000, 4'(a), 4'(b), 16'h0000};
        apply_and_check($sformatf("hand%0d_%0d", a, b), x, model(x));
      end

    for (int n = 0; n < 300; n++) begin
      x = rand_in($urandom_range(0, 19) != 0);
      apply_and_check($sformatf("rand%0d", n), x, model(x));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/card_eval_unit.md
Name: card_eval_unit

Overview:
- Registered evaluation datapath for the two-player Black-and-White card game.
- Each player holds cards 0..8. Odd-valued cards are black; even-valued cards are white.
- Combines three functions behind one register stage:
  - per-player remaining black/white card counts (blackandwhite function)
  - played-card comparison giving the match result (compare function)
  - one-hot switch selection converted to a card index (encoder function)
- Sits between the game FSM and the display/score logic in the top level.

Parameters:
- NUM_CARDS, 9, number of cards per player; card value k maps to bit k of a card mask.
- ENC_WIDTH, 16, width of the encoder input vector; bits at and above NUM_CARDS are tied 0 by the integrator.
- IDX_WIDTH, 4, width of a card value or encoder index; must satisfy 2**IDX_WIDTH >= ENC_WIDTH.

Ports:
- clk, input, 1, system clock; all state updates on its rising edge.
- resetn, input, 1, synchronous active-low reset.
- p1_cards, input, NUM_CARDS, player-1 remaining-card mask; bit k=1 means card k is still held.
- p2_cards, input, NUM_CARDS, player-2 remaining-card mask.
- p1_hand, input, IDX_WIDTH, card value played by player 1 (legal 0..8).
- p2_hand, input, IDX_WIDTH, card value played by player 2 (legal 0..8).
- sel_vec, input, ENC_WIDTH, selection vector (switches) to encode.
- p1_black, output, 4, count of set odd-indexed bits in p1_cards (0..4).
- p1_white, output, 4, count of set even-indexed bits in p1_cards (0..5).
- p2_black, output, 4, same as p1_black for p2_cards.
- p2_white, output, 4, same as p1_white for p2_cards.
- match_result, output, 2, comparison of p1_hand against p2_hand.
- p1_hand_black, output, 1, equals p1_hand[0].
- p2_hand_black, output, 1, equals p2_hand[0].
- sel_index, output, IDX_WIDTH, encoded index of sel_vec.
- sel_valid, output, 1, 1 when sel_vec is non-zero.

Behaviour:
- Reset: if resetn=0 at a rising clk edge, every output register becomes 0. This includes match_result=2'b00 and sel_valid=0. Reset takes priority over new inputs. Reset is never asynchronous.
- Latency: outputs are registered. The inputs present at edge N appear on the outputs after edge N. Latency is exactly 1 cycle, with no enable or handshake; the unit recomputes and re-registers every cycle.
- Black count: number of 1s among card-mask bits 1,3,5,7. Width 4 bits, never overflows.
- White count: number of 1s among card-mask bits 0,2,4,6,8. Width 4 bits, never overflows.
- Full mask 9'h1FF gives black=4, white=5. Empty mask gives black=0, white=0.
- match_result is an unsigned magnitude compare:
  - 2'b01 when p1_hand > p2_hand (player 1 wins)
  - 2'b10 when p2_hand > p1_hand (player 2 wins)
  - 2'b00 when equal (draw)
  - 2'b11 is never produced.
- Out-of-range hand values (9..15) are still compared unsigned; no error flag is raised.
- Encoder is a priority encoder: sel_index is the position of the highest set bit of sel_vec.
  - sel_vec=0 gives sel_index=0 and sel_valid=0.
  - A single set bit k gives sel_index=k and sel_valid=1.
  - Multiple set bits: the highest index wins.
- p1_hand_black and p2_hand_black are registered copies of bit 0 of the corresponding hand input.
- Input changes within a cycle have no effect until the next rising edge. There are no glitches on the outputs.

Decomposition:
- Shared package holds:
  - constants NUM_CARDS=9 and CARD_W=4
  - MATCH_DRAW=2'b00, MATCH_P1=2'b01, MATCH_P2=2'b10
  - the typedef for the 2-bit match-result code
- One natural sub-module: card_color_count (combinational, mask in, black/white counts out), instantiated twice, once per player.
- Compare and priority-encode logic stay inline in card_eval_unit.

Test Plan:
- Reset: hold resetn=0 with all inputs driven to non-zero values (p1_cards=9'h1FF, p1_hand=8, sel_vec=16'h0100) -> after the edge all outputs are 0. Release resetn -> the next edge shows p1_black=4, p1_white=5, sel_index=8, sel_valid=1.
- Counts: p1_cards=9'b000001010 (cards 1,3) and p2_cards=9'b100010001 (cards 0,4,8) -> one cycle later p1_black=2, p1_white=0, p2_black=0, p2_white=3.
- Compare: apply p1_hand/p2_hand = 7/3 -> match_result=2'b01. Then 2/6 -> 2'b10. Then 5/5 -> 2'b00. Check p1_hand_black=1 for 7 and p2_hand_black=0 for 6.
- Encoder: sel_vec=16'h0001 -> index 0, valid 1. sel_vec=16'h0000 -> index 0, valid 0. sel_vec=16'h0012 -> index 4, valid 1 (priority to the highest set bit).
- Latency/mid-op reset: change inputs every cycle and check each output equals the model of the previous cycle's inputs. Assert resetn=0 for one cycle mid-stream -> outputs are 0 for exactly that cycle, then tracking resumes.
- Exhaustive sweep: all 512 card masks for both players -> counts match popcount of the odd/even bits. All 81 legal hand pairs -> match_result matches the unsigned compare.
